// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory stage controller sitting between execute and the D-cache.
// Accepts one op at a time. Loads and stores become a single aligned cache request
// with lane-shifted store data and byte strobes; load data comes back shifted to
// bit 0 and sign- or zero-extended. Pass-through ops complete the following cycle.
// Optional feature: define MM_MISALIGN_CHK_EN to trap misaligned accesses
// (out_misalign pulse, no cache request). Otherwise the address is aligned down.

module mem_stage_ctrl #(
   parameter int DATA_WIDTH  = 64,
   parameter int ADDR_WIDTH  = 64,
   parameter int REGNO_WIDTH = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   input  logic                    in_mem_req,
   input  logic [3:0]              in_op,
   input  logic [ADDR_WIDTH-1:0]   in_addr,
   input  logic [DATA_WIDTH-1:0]   in_store_data,
   input  logic [REGNO_WIDTH-1:0]  in_rd_regno,
   input  logic                    in_update_rd,
   input  logic                    in_flush,
   output logic                    out_ready,
   output logic                    cache_req_valid,
   output logic                    cache_req_write,
   output logic [ADDR_WIDTH-1:0]   cache_req_addr,
   output logic [DATA_WIDTH-1:0]   cache_req_wdata,
   output logic [DATA_WIDTH/8-1:0] cache_req_wstrb,
   input  logic                    cache_req_ready,
   input  logic                    cache_resp_valid,
   input  logic [DATA_WIDTH-1:0]   cache_resp_rdata,
   output logic                    out_valid,
   output logic [DATA_WIDTH-1:0]   out_wb_data,
   output logic [REGNO_WIDTH-1:0]  out_rd_regno,
   output logic                    out_update_rd,
   output logic                    out_misalign
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int OFF_WIDTH  = $clog2(STRB_WIDTH);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

   state_t                  state, state_next;
   logic [3:0]              op_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   store_data_q;
   logic [REGNO_WIDTH-1:0]  rd_regno_q;
   logic                    update_rd_q;

   logic                    capture;
   logic                    res_valid;
   logic [DATA_WIDTH-1:0]   res_data;
   logic [REGNO_WIDTH-1:0]  res_regno;
   logic                    res_update;
   logic                    res_misalign;

   // A doubleword access on a 32-bit data path behaves as a word access
   function automatic logic [1:0] eff_size(input logic [1:0] code);
      logic [1:0] size;
      size = code;
      if (DATA_WIDTH == 32 && code == 2'd3) size = 2'd2;
      return size;
   endfunction

   // Address bits that must be zero for a naturally aligned access of this size
   function automatic logic [ADDR_WIDTH-1:0] size_mask(input logic [1:0] size);
      logic [ADDR_WIDTH-1:0] mask;
      mask = '0;
      case (size)
         2'd0:    mask = '0;
         2'd1:    mask[0] = 1'b1;
         2'd2:    mask[1:0] = 2'b11;
         default: mask[2:0] = 3'b111;
      endcase
      return mask;
   endfunction

   logic [1:0]            in_size;
   logic [ADDR_WIDTH-1:0] in_addr_aligned;

   assign in_size         = eff_size(in_op[1:0]);
   assign in_addr_aligned = in_addr & ~size_mask(in_size);

`ifdef MM_MISALIGN_CHK_EN
   logic in_misaligned;
   assign in_misaligned = |(in_addr & size_mask(in_size));
`endif

   logic [1:0]            req_size;
   logic [OFF_WIDTH-1:0]  req_off;
   logic [STRB_WIDTH-1:0] strb_base;

   assign req_size  = eff_size(op_q[1:0]);
   assign req_off   = addr_q[OFF_WIDTH-1:0];
   assign strb_base = STRB_WIDTH'((16'd1 << (5'd1 << req_size)) - 16'd1);
   assign out_ready = (state == IDLE);

   logic [DATA_WIDTH-1:0] resp_shifted;
   logic [DATA_WIDTH-1:0] keep_mask;
   logic [DATA_WIDTH-1:0] sign_mask;
   logic [DATA_WIDTH-1:0] load_value;
   logic                  load_sign;

   // Pull the addressed lane of the cache word down to bit 0 and extend it
   always_comb begin
      resp_shifted = cache_resp_rdata >> {req_off, 3'b000};
      keep_mask    = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - (8 << req_size));
      sign_mask    = keep_mask ^ (keep_mask >> 1);
      load_sign    = (|(resp_shifted & sign_mask)) && !op_q[2];
      load_value   = (resp_shifted & keep_mask) | (load_sign ? ~keep_mask : '0);
   end

   // Cache request is driven from captured fields only, so it stays stable while in REQ
   always_comb begin
      cache_req_valid = (state == REQ);
      cache_req_write = 1'b0;
      cache_req_addr  = '0;
      cache_req_wdata = '0;
      cache_req_wstrb = '0;
      if (state == REQ) begin
         cache_req_write = op_q[3];
         cache_req_addr  = {addr_q[ADDR_WIDTH-1:OFF_WIDTH], {OFF_WIDTH{1'b0}}};
         cache_req_wdata = store_data_q << {req_off, 3'b000};
         cache_req_wstrb = strb_base << req_off;
      end
   end

   // Next state plus the result that will be registered onto the out_* pulse
   always_comb begin
      state_next   = state;
      capture      = 1'b0;
      res_valid    = 1'b0;
      res_data     = '0;
      res_regno    = rd_regno_q;
      res_update   = 1'b0;
      res_misalign = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid && !in_flush) begin
               res_regno = in_rd_regno;
               if (!in_mem_req) begin
                  res_valid  = 1'b1;
                  res_data   = DATA_WIDTH'(in_addr);
                  res_update = in_update_rd;
               end
`ifdef MM_MISALIGN_CHK_EN
               else if (in_misaligned) begin
                  res_valid    = 1'b1;
                  res_misalign = 1'b1;
               end
`endif
               else begin
                  capture    = 1'b1;
                  state_next = REQ;
               end
            end
         end
         REQ: begin
            if (cache_req_ready) begin
               if (op_q[3]) begin
                  state_next = IDLE;
                  res_valid  = !in_flush;
               end else begin
                  state_next = in_flush ? DRAIN : WAIT;
               end
            end else if (in_flush) begin
               state_next = IDLE;
            end
         end
         WAIT: begin
            if (cache_resp_valid) begin
               state_next = IDLE;
               res_valid  = !in_flush;
               res_data   = load_value;
               res_update = update_rd_q;
            end else if (in_flush) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (cache_resp_valid) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State register, captured op fields and the registered result pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         op_q          <= '0;
         addr_q        <= '0;
         store_data_q  <= '0;
         rd_regno_q    <= '0;
         update_rd_q   <= 1'b0;
         out_valid     <= 1'b0;
         out_wb_data   <= '0;
         out_rd_regno  <= '0;
         out_update_rd <= 1'b0;
         out_misalign  <= 1'b0;
      end else begin
         state         <= state_next;
         out_valid     <= res_valid;
         out_wb_data   <= res_data;
         out_rd_regno  <= res_regno;
         out_update_rd <= res_update;
         out_misalign  <= res_misalign;
         if (capture) begin
            op_q         <= in_op;
            addr_q       <= in_addr_aligned;
            store_data_q <= in_store_data;
            rd_regno_q   <= in_rd_regno;
            update_rd_q  <= in_update_rd;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Testbench for mem_stage_ctrl (default 64-bit configuration).
// Inputs change and outputs are observed on the falling clock edge.
// Expectations follow MM_MISALIGN_CHK_EN the same way the design does.

module tb_mem_stage_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_mem_req;
   logic [3:0]  in_op;
   logic [63:0] in_addr;
   logic [63:0] in_store_data;
   logic [4:0]  in_rd_regno;
   logic        in_update_rd;
   logic        in_flush;
   logic        out_ready;
   logic        cache_req_valid;
   logic        cache_req_write;
   logic [63:0] cache_req_addr;
   logic [63:0] cache_req_wdata;
   logic [7:0]  cache_req_wstrb;
   logic        cache_req_ready;
   logic        cache_resp_valid;
   logic [63:0] cache_resp_rdata;
   logic        out_valid;
   logic [63:0] out_wb_data;
   logic [4:0]  out_rd_regno;
   logic        out_update_rd;
   logic        out_misalign;

   int checks = 0;
   int errors = 0;

   mem_stage_ctrl dut (
      .clk              (clk),
      .reset            (reset),
      .in_valid         (in_valid),
      .in_mem_req       (in_mem_req),
      .in_op            (in_op),
      .in_addr          (in_addr),
      .in_store_data    (in_store_data),
      .in_rd_regno      (in_rd_regno),
      .in_update_rd     (in_update_rd),
      .in_flush         (in_flush),
      .out_ready        (out_ready),
      .cache_req_valid  (cache_req_valid),
      .cache_req_write  (cache_req_write),
      .cache_req_addr   (cache_req_addr),
      .cache_req_wdata  (cache_req_wdata),
      .cache_req_wstrb  (cache_req_wstrb),
      .cache_req_ready  (cache_req_ready),
      .cache_resp_valid (cache_resp_valid),
      .cache_resp_rdata (cache_resp_rdata),
      .out_valid        (out_valid),
      .out_wb_data      (out_wb_data),
      .out_rd_regno     (out_rd_regno),
      .out_update_rd    (out_update_rd),
      .out_misalign     (out_misalign)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Guard against a hung run
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, required $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference load result: pick bytes at the offset, keep the access size, extend
   function automatic logic [63:0] model_load(input logic [63:0] rdata, input logic [3:0] op, input int off);
      int          bits;
      logic [63:0] v;
      logic [63:0] lim;
      bits = 8 << op[1:0];
      v = rdata >> (off * 8);
      if (bits < 64) begin
         lim = 64'd1 << bits;
         v = v % lim;
         if (!op[2] && v >= (lim >> 1)) v = v - lim;
      end
      return v;
   endfunction

   task automatic cycle();
      @(negedge clk);
   endtask

   task automatic drive_op(input logic mem, input logic [3:0] op, input logic [63:0] addr,
                           input logic [63:0] sdata, input logic [4:0] regno, input logic upd);
      in_valid = 1'b1; in_mem_req = mem; in_op = op; in_addr = addr;
      in_store_data = sdata; in_rd_regno = regno; in_update_rd = upd;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cycle(); cycle();
      checks++; if (out_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %0b required 1", out_ready); end
      checks++; if (cache_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid: got %0b required 0", cache_req_valid); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0b required 0", out_valid); end
      checks++; if ({out_wb_data, out_rd_regno, out_update_rd, out_misalign} !== '0) begin errors++;
         $display("[TB] FAIL reset_out_fields: got %h/%0d/%0b/%0b required all 0", out_wb_data, out_rd_regno, out_update_rd, out_misalign); end
      checks++; if ({cache_req_write, cache_req_addr, cache_req_wdata, cache_req_wstrb} !== '0) begin errors++;
         $display("[TB] FAIL reset_req_fields: got %0b/%h/%h/%h required all 0", cache_req_write, cache_req_addr, cache_req_wdata, cache_req_wstrb); end
      reset = 1'b0;
   endtask

   task automatic test_passthrough_b2b();
      drive_op(1'b0, 4'h0, 64'h11, 64'h0, 5'd1, 1'b1);
      cycle();
      checks++; if (out_valid !== 1'b1 || out_wb_data !== 64'h11 || out_rd_regno !== 5'd1) begin errors++;
         $display("[TB] FAIL pass_first: got valid=%0b data=%h rd=%0d required 1/11/1", out_valid, out_wb_data, out_rd_regno); end
      drive_op(1'b0, 4'h0, 64'h22, 64'h0, 5'd2, 1'b1);
      cycle();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_wb_data !== 64'h22 || out_rd_regno !== 5'd2) begin errors++;
         $display("[TB] FAIL pass_second: got valid=%0b data=%h rd=%0d required 1/22/2", out_valid, out_wb_data, out_rd_regno); end
      cycle();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL pass_end: got valid=%0b required 0", out_valid); end
   endtask

   task automatic test_load_lb();
      drive_op(1'b1, 4'b0000, 64'h1007, 64'h0, 5'd7, 1'b1);
      cycle();
      in_valid = 1'b0;
      checks++; if (cache_req_valid !== 1'b1 || cache_req_write !== 1'b0 || cache_req_addr !== 64'h1000) begin errors++;
         $display("[TB] FAIL lb_req: got valid=%0b write=%0b addr=%h required 1/0/1000", cache_req_valid, cache_req_write, cache_req_addr); end
      cache_req_ready = 1'b1;
      cycle();
      cache_req_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || cache_req_valid !== 1'b0) begin errors++;
         $display("[TB] FAIL lb_wait: got out_valid=%0b req_valid=%0b required 0/0", out_valid, cache_req_valid); end
      cache_resp_valid = 1'b1; cache_resp_rdata = 64'h80A1_B2C3_D4E5_F607;
      cycle();
      cache_resp_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_wb_data !== 64'hFFFF_FFFF_FFFF_FF80 || out_rd_regno !== 5'd7 || out_update_rd !== 1'b1) begin errors++;
         $display("[TB] FAIL lb_result: got valid=%0b data=%h rd=%0d upd=%0b required 1/ffffffffffffff80/7/1", out_valid, out_wb_data, out_rd_regno, out_update_rd); end
      cycle();
      checks++; if (out_valid !== 1'b0 || out_ready !== 1'b1) begin errors++;
         $display("[TB] FAIL lb_end: got valid=%0b ready=%0b required 0/1", out_valid, out_ready); end
   endtask

   task automatic test_store_sh();
      int pulses;
      pulses = 0;
      drive_op(1'b1, 4'b1001, 64'h2002, 64'hBEEF, 5'd3, 1'b1);
      cycle();
      in_valid = 1'b0;
      for (int w = 0; w < 4; w++) begin
         checks++; if ({cache_req_valid, cache_req_write, cache_req_addr, cache_req_wstrb, cache_req_wdata} !== {1'b1, 1'b1, 64'h2000, 8'h0C, 64'h0000_0000_BEEF_0000}) begin errors++;
            $display("[TB] FAIL sh_req_hold%0d: got v=%0b w=%0b a=%h s=%h d=%h required 1/1/2000/0c/00000000beef0000", w, cache_req_valid, cache_req_write, cache_req_addr, cache_req_wstrb, cache_req_wdata); end
         if (out_valid) pulses++;
         if (w == 3) cache_req_ready = 1'b1;
         cycle();
      end
      cache_req_ready = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_update_rd !== 1'b0) begin errors++;
         $display("[TB] FAIL sh_result: got valid=%0b upd=%0b required 1/0", out_valid, out_update_rd); end
      if (out_valid) pulses++;
      for (int w = 0; w < 2; w++) begin
         cycle();
         if (out_valid) pulses++;
      end
      checks++; if (pulses !== 1) begin errors++; $display("[TB] FAIL sh_pulses: got %0d required 1", pulses); end
   endtask

   task automatic test_flush_wait();
      drive_op(1'b1, 4'b0110, 64'h3004, 64'h0, 5'd9, 1'b1);
      cycle();
      in_valid = 1'b0;
      cache_req_ready = 1'b1;
      cycle();
      cache_req_ready = 1'b0;
      in_flush = 1'b1;
      cycle();
      in_flush = 1'b0;
      checks++; if (out_ready !== 1'b0 || out_valid !== 1'b0) begin errors++;
         $display("[TB] FAIL lwu_drain: got ready=%0b valid=%0b required 0/0", out_ready, out_valid); end
      cycle();
      checks++; if (out_ready !== 1'b0) begin errors++; $display("[TB] FAIL lwu_drain_hold: got ready=%0b required 0", out_ready); end
      cache_resp_valid = 1'b1; cache_resp_rdata = 64'h1234_5678_9ABC_DEF0;
      cycle();
      cache_resp_valid = 1'b0;
      checks++; if (out_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
         $display("[TB] FAIL lwu_after_resp: got ready=%0b valid=%0b required 1/0", out_ready, out_valid); end
   endtask

   task automatic test_misalign();
      logic [63:0] rdata;
      rdata = {$urandom, $urandom};
      drive_op(1'b1, 4'b0011, 64'h4004, 64'h0, 5'd4, 1'b1);
      cycle();
      in_valid = 1'b0;
`ifdef MM_MISALIGN_CHK_EN
      checks++; if (out_valid !== 1'b1 || out_misalign !== 1'b1 || out_update_rd !== 1'b0 || cache_req_valid !== 1'b0) begin errors++;
         $display("[TB] FAIL ld_misalign: got valid=%0b mis=%0b upd=%0b req=%0b required 1/1/0/0", out_valid, out_misalign, out_update_rd, cache_req_valid); end
      cycle();
      checks++; if (out_valid !== 1'b0 || out_ready !== 1'b1) begin errors++;
         $display("[TB] FAIL ld_misalign_end: got valid=%0b ready=%0b required 0/1", out_valid, out_ready); end
`else
      checks++; if (cache_req_valid !== 1'b1 || cache_req_addr !== 64'h4000 || cache_req_write !== 1'b0) begin errors++;
         $display("[TB] FAIL ld_align_req: got valid=%0b addr=%h write=%0b required 1/4000/0", cache_req_valid, cache_req_addr, cache_req_write); end
      cache_req_ready = 1'b1;
      cycle();
      cache_req_ready = 1'b0;
      cache_resp_valid = 1'b1; cache_resp_rdata = rdata;
      cycle();
      cache_resp_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_wb_data !== rdata || out_misalign !== 1'b0 || out_update_rd !== 1'b1) begin errors++;
         $display("[TB] FAIL ld_align_result: got valid=%0b data=%h mis=%0b upd=%0b required 1/%h/0/1", out_valid, out_wb_data, out_misalign, out_update_rd, rdata); end
      cycle();
`endif
   endtask

   task automatic test_flush_req();
      drive_op(1'b1, 4'b1010, 64'h5008, 64'h55, 5'd5, 1'b1);
      cycle();
      in_valid = 1'b0;
      in_flush = 1'b1;
      cycle();
      in_flush = 1'b0;
      checks++; if (cache_req_valid !== 1'b0 || out_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
         $display("[TB] FAIL flush_req: got req=%0b ready=%0b valid=%0b required 0/1/0", cache_req_valid, out_ready, out_valid); end
      cycle();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_req_late: got valid=%0b required 0", out_valid); end
   endtask

   task automatic test_flush_handshake();
      // store handshake with flush: request seen by cache, result suppressed
      drive_op(1'b1, 4'b1011, 64'h6010, 64'h77, 5'd6, 1'b1);
      cycle();
      in_valid = 1'b0;
      checks++; if (cache_req_valid !== 1'b1 || cache_req_write !== 1'b1) begin errors++;
         $display("[TB] FAIL flush_st_req: got valid=%0b write=%0b required 1/1", cache_req_valid, cache_req_write); end
      cache_req_ready = 1'b1; in_flush = 1'b1;
      cycle();
      cache_req_ready = 1'b0; in_flush = 1'b0;
      checks++; if (out_valid !== 1'b0 || out_ready !== 1'b1) begin errors++;
         $display("[TB] FAIL flush_st_done: got valid=%0b ready=%0b required 0/1", out_valid, out_ready); end
      // load handshake with flush: drain the response without a result
      drive_op(1'b1, 4'b0010, 64'h7000, 64'h0, 5'd8, 1'b1);
      cycle();
      in_valid = 1'b0;
      cache_req_ready = 1'b1; in_flush = 1'b1;
      cycle();
      cache_req_ready = 1'b0; in_flush = 1'b0;
      checks++; if (out_ready !== 1'b0 || cache_req_valid !== 1'b0) begin errors++;
         $display("[TB] FAIL flush_ld_drain: got ready=%0b req=%0b required 0/0", out_ready, cache_req_valid); end
      cache_resp_valid = 1'b1; cache_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      cycle();
      cache_resp_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || out_ready !== 1'b1) begin errors++;
         $display("[TB] FAIL flush_ld_done: got valid=%0b ready=%0b required 0/1", out_valid, out_ready); end
   endtask

   task automatic test_flush_idle();
      drive_op(1'b1, 4'b0011, 64'h8000, 64'h0, 5'd10, 1'b1);
      in_flush = 1'b1;
      cycle();
      in_valid = 1'b0; in_flush = 1'b0;
      checks++; if (cache_req_valid !== 1'b0 || out_valid !== 1'b0 || out_ready !== 1'b1) begin errors++;
         $display("[TB] FAIL flush_idle: got req=%0b valid=%0b ready=%0b required 0/0/1", cache_req_valid, out_valid, out_ready); end
   endtask

   task automatic test_reset_mid();
      drive_op(1'b1, 4'b0001, 64'h9002, 64'h0, 5'd11, 1'b1);
      cycle();
      in_valid = 1'b0;
      cache_req_ready = 1'b1;
      cycle();
      cache_req_ready = 1'b0;
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      checks++; if (out_ready !== 1'b1 || cache_req_valid !== 1'b0 || out_valid !== 1'b0) begin errors++;
         $display("[TB] FAIL reset_mid: got ready=%0b req=%0b valid=%0b required 1/0/0", out_ready, cache_req_valid, out_valid); end
      // late response for the abandoned load is ignored in IDLE
      cache_resp_valid = 1'b1; cache_resp_rdata = 64'hAAAA_5555_AAAA_5555;
      cycle();
      cache_resp_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || out_ready !== 1'b1) begin errors++;
         $display("[TB] FAIL stray_resp: got valid=%0b ready=%0b required 0/1", out_valid, out_ready); end
   endtask

   task automatic test_random();
      logic [63:0] addr, sdata, rdata, exp_addr, exp_wdata, exp_wb;
      logic [7:0]  exp_strb;
      logic [3:0]  op;
      logic [4:0]  regno;
      logic        upd, mis;
      int          kind, bytes, off, rdly, sdly;
      for (int i = 0; i < 40; i++) begin
         kind  = int'($urandom_range(0, 2));
         op    = 4'($urandom_range(0, 7));
         op[3] = (kind == 2);
         addr  = {32'h0, $urandom};
         sdata = {$urandom, $urandom};
         rdata = {$urandom, $urandom};
         regno = 5'($urandom);
         upd   = 1'($urandom);
         rdly  = int'($urandom_range(0, 2));
         sdly  = int'($urandom_range(0, 2));
         bytes = 1 << op[1:0];
         mis   = (int'(addr[2:0]) % bytes) != 0;
         off   = int'(addr[2:0]) - (int'(addr[2:0]) % bytes);
         exp_addr  = addr - 64'(addr[2:0]);
         exp_strb  = 8'(((1 << bytes) - 1) << off);
         exp_wdata = sdata << (off * 8);
         exp_wb    = model_load(rdata, op, off);
         drive_op(kind != 0, op, addr, sdata, regno, upd);
         cycle();
         in_valid = 1'b0;
         if (kind == 0) begin
            checks++; if (out_valid !== 1'b1 || out_wb_data !== addr || out_rd_regno !== regno || out_update_rd !== upd) begin errors++;
               $display("[TB] FAIL rnd%0d_pass: got v=%0b d=%h rd=%0d u=%0b required 1/%h/%0d/%0b", i, out_valid, out_wb_data, out_rd_regno, out_update_rd, addr, regno, upd); end
         end
`ifdef MM_MISALIGN_CHK_EN
         else if (mis) begin
            checks++; if (out_valid !== 1'b1 || out_misalign !== 1'b1 || out_update_rd !== 1'b0 || cache_req_valid !== 1'b0) begin errors++;
               $display("[TB] FAIL rnd%0d_mis: got v=%0b m=%0b u=%0b req=%0b required 1/1/0/0", i, out_valid, out_misalign, out_update_rd, cache_req_valid); end
         end
`endif
         else begin
            for (int w = 0; w <= rdly; w++) begin
               checks++; if (cache_req_valid !== 1'b1 || cache_req_write !== op[3] || cache_req_addr !== exp_addr) begin errors++;
                  $display("[TB] FAIL rnd%0d_req: got v=%0b w=%0b a=%h required 1/%0b/%h", i, cache_req_valid, cache_req_write, cache_req_addr, op[3], exp_addr); end
               if (op[3]) begin
                  checks++; if (cache_req_wstrb !== exp_strb || cache_req_wdata !== exp_wdata) begin errors++;
                     $display("[TB] FAIL rnd%0d_wr: got s=%h d=%h required %h/%h", i, cache_req_wstrb, cache_req_wdata, exp_strb, exp_wdata); end
               end
               if (w == rdly) cache_req_ready = 1'b1;
               cycle();
            end
            cache_req_ready = 1'b0;
            if (op[3]) begin
               checks++; if (out_valid !== 1'b1 || out_update_rd !== 1'b0 || out_misalign !== 1'b0) begin errors++;
                  $display("[TB] FAIL rnd%0d_st: got v=%0b u=%0b m=%0b required 1/0/0", i, out_valid, out_update_rd, out_misalign); end
            end else begin
               for (int w = 0; w < sdly; w++) begin
                  checks++; if (out_valid !== 1'b0 || out_ready !== 1'b0) begin errors++;
                     $display("[TB] FAIL rnd%0d_wait: got v=%0b r=%0b required 0/0", i, out_valid, out_ready); end
                  cycle();
               end
               cache_resp_valid = 1'b1; cache_resp_rdata = rdata;
               cycle();
               cache_resp_valid = 1'b0;
               checks++; if (out_valid !== 1'b1 || out_wb_data !== exp_wb || out_rd_regno !== regno || out_update_rd !== upd) begin errors++;
                  $display("[TB] FAIL rnd%0d_ld: got v=%0b d=%h rd=%0d u=%0b required 1/%h/%0d/%0b", i, out_valid, out_wb_data, out_rd_regno, out_update_rd, exp_wb, regno, upd); end
            end
         end
         cycle();
         checks++; if (out_valid !== 1'b0 || out_ready !== 1'b1) begin errors++;
            $display("[TB] FAIL rnd%0d_end: got v=%0b r=%0b required 0/1", i, out_valid, out_ready); end
      end
   endtask

   // Test sequence
   initial begin
      reset = 1'b1; in_valid = 1'b0; in_mem_req = 1'b0; in_op = '0; in_addr = '0;
      in_store_data = '0; in_rd_regno = '0; in_update_rd = 1'b0; in_flush = 1'b0;
      cache_req_ready = 1'b0; cache_resp_valid = 1'b0; cache_resp_rdata = '0;
      test_reset();
      cycle();
      test_passthrough_b2b();
      test_load_lb();
      test_store_sh();
      test_flush_wait();
      test_misalign();
      test_flush_req();
      test_flush_handshake();
      test_flush_idle();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 64, sets data path and register width; SHALL be 32 or 64.
REQ-002 Parameter ADDR_WIDTH, default 64, sets virtual/physical address width.
REQ-003 Parameter REGNO_WIDTH, default 5, sets destination register number width.
REQ-004 Ports SHALL be, one clock, reset synchronous active-high:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  upstream op present
- in_mem_req  in  1  1=load/store, 0=pass-through
- in_op  in  4  [1:0]=log2 bytes (B/H/W/D), [2]=zero-extend, [3]=store
- in_addr  in  ADDR_WIDTH  effective address, or ALU result for pass-through
- in_store_data  in  DATA_WIDTH  rs2 value
- in_rd_regno  in  REGNO_WIDTH  destination register
- in_update_rd  in  1  writeback enable
- in_flush  in  1  kill in-flight op
- out_ready  out  1  stage can accept
- cache_req_valid  out  1  request to D-cache
- cache_req_write  out  1  1=store
- cache_req_addr  out  ADDR_WIDTH  address aligned down to DATA_WIDTH/8
- cache_req_wdata  out  DATA_WIDTH  lane-shifted store data
- cache_req_wstrb  out  DATA_WIDTH/8  byte enables
- cache_req_ready  in  1  cache accepts request
- cache_resp_valid  in  1  load data valid
- cache_resp_rdata  in  DATA_WIDTH  aligned cache word
- out_valid  out  1  one-cycle result pulse
- out_wb_data  out  DATA_WIDTH  extended load data or pass-through value
- out_rd_regno  out  REGNO_WIDTH  registered in_rd_regno
- out_update_rd  out  1  registered writeback enable
- out_misalign  out  1  misaligned-access exception flag

Function
REQ-005 FSM states SHALL be IDLE, REQ, WAIT, DRAIN; out_ready SHALL be 1 only in IDLE.
REQ-006 Accept SHALL occur on in_valid & out_ready; all in_* fields are captured at accept.
REQ-007 Pass-through accept SHALL pulse out_valid on the next cycle with out_wb_data=in_addr; the FSM stays in IDLE.
REQ-008 Memory accept SHALL go to REQ; cache_req_valid SHALL be 1 in REQ, with all cache_req_* held stable until cache_req_ready.
REQ-009 Store handshake in REQ SHALL return to IDLE and pulse out_valid the next cycle with out_update_rd=0.
REQ-010 Load handshake in REQ SHALL go to WAIT; cache_resp_valid in WAIT SHALL return to IDLE and pulse out_valid the next cycle.
REQ-011 Byte offset off = in_addr[log2(DATA_WIDTH/8)-1:0].
- Load data SHALL be cache_resp_rdata >> (off*8), truncated to the access size.
- Load data SHALL be sign-extended, or zero-extended when in_op[2]=1, to DATA_WIDTH.
REQ-012 Store wstrb SHALL be ((1<<(1<<size))-1)<<off; wdata SHALL be in_store_data<<(off*8).
REQ-013 With DATA_WIDTH=32, size code 3 SHALL be treated as W.
REQ-014 in_flush in REQ without cache_req_ready SHALL go to IDLE with no out_valid.
REQ-015 in_flush in WAIT, or in the same cycle as a load handshake, SHALL go to DRAIN.
- DRAIN SHALL wait for cache_resp_valid, then go to IDLE; no out_valid is produced.
REQ-016 in_flush in the same cycle as a store handshake SHALL leave the store committed and suppress out_valid.
REQ-017 in_flush in IDLE SHALL block accept that cycle.
REQ-018 A cache_resp_valid arriving outside WAIT or DRAIN SHALL be ignored.

Reset
REQ-019 Reset SHALL force state IDLE; all outputs 0 except out_ready=1.
REQ-020 Reset mid-transaction SHALL abandon it; no DRAIN is performed.

Configuration
REQ-021 Macro MM_MISALIGN_CHK_EN:
- Defined: an access with addr[size-1:0]!=0 SHALL issue no cache request and SHALL pulse out_valid the next cycle with out_misalign=1 and out_update_rd=0.
- Undefined: the low size bits of the address SHALL be forced to 0 (align down), and out_misalign SHALL be tied to 0.

Verification
REQ-022 Load lb, addr 0x1007, rdata 0x80xx_xxxx_xxxx_xxxx -> cache_req_addr 0x1000; out_wb_data 0xFFFF_FFFF_FFFF_FF80, 1 cycle after resp.
REQ-023 Store sh, addr 0x2002, data 0xBEEF, cache_req_ready delayed 3 cycles -> wstrb 0x0C, wdata[31:16]=0xBEEF; request held stable; out_valid once.
REQ-024 Load lwu, addr 0x3004, flush asserted in WAIT, resp arrives 2 cycles later -> no out_valid; out_ready returns the cycle after resp.
REQ-025 Back-to-back pass-throughs 0x11, 0x22 -> out_valid on 2 consecutive cycles with the matching data.
REQ-026 ld at 0x4004 -> MM_MISALIGN_CHK_EN defined: out_misalign=1, no cache_req_valid; undefined: cache_req_addr 0x4000, normal completion.
